// File: rtl/idex_skid_reg_if.sv
// idex_skid_reg_if: decode -> execute handshake bundle for the ID/EX pipeline register.
// Ports: in_* side (decode bundle + in_valid/in_ready), out side (registered bundle + out_valid/out_ready).
// master = surrounding pipeline (drives decode bundle, consumes execute bundle); slave = the register.
interface idex_skid_reg_if #(
  parameter int XLEN    = 64,
  parameter int RA_W    = 5,
  parameter int FUNCT_W = 4,
  parameter int ALUOP_W = 2
);
  // decode side
  logic               in_valid;
  logic               in_ready;
  logic [XLEN-1:0]    pc_in;
  logic [XLEN-1:0]    rdata1_in;
  logic [XLEN-1:0]    rdata2_in;
  logic [XLEN-1:0]    imm_in;
  logic [RA_W-1:0]    rs1_in;
  logic [RA_W-1:0]    rs2_in;
  logic [RA_W-1:0]    rd_in;
  logic [FUNCT_W-1:0] funct_in;
  logic [5:0]         ctrl_in;   // {branch, memread, memtoreg, memwrite, regwrite, alusrc}
  logic [ALUOP_W-1:0] aluop_in;

  // execute side
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    pc;
  logic [XLEN-1:0]    rdata1;
  logic [XLEN-1:0]    rdata2;
  logic [XLEN-1:0]    imm;
  logic [RA_W-1:0]    rs1;
  logic [RA_W-1:0]    rs2;
  logic [RA_W-1:0]    rd;
  logic [FUNCT_W-1:0] funct_out;
  logic [5:0]         ctrl_out;
  logic [ALUOP_W-1:0] aluop;

  modport master (
    output in_valid, pc_in, rdata1_in, rdata2_in, imm_in,
           rs1_in, rs2_in, rd_in, funct_in, ctrl_in, aluop_in,
    input  in_ready,
    input  out_valid, pc, rdata1, rdata2, imm, rs1, rs2, rd,
           funct_out, ctrl_out, aluop,
    output out_ready
  );

  modport slave (
    input  in_valid, pc_in, rdata1_in, rdata2_in, imm_in,
           rs1_in, rs2_in, rd_in, funct_in, ctrl_in, aluop_in,
    output in_ready,
    output out_valid, pc, rdata1, rdata2, imm, rs1, rs2, rd,
           funct_out, ctrl_out, aluop,
    input  out_ready
  );
endinterface

// File: rtl/idex_skid_reg.sv
// idex_skid_reg: ID/EX pipeline register with a 2-entry skid buffer, flush and bubble-safe control.
// Latency: 1 cycle in->out when unstalled; full throughput (one bundle per cycle).
// Backpressure: in_ready = !skid_valid (registered, no combinational path from out_ready).
// Ports: clk, reset (sync, active-high), flush (sync squash), bus (idex_skid_reg_if.slave),
//        stall_cnt / flush_cnt perf counters.
// Optional feature: define IDEX_PERF_CNT_EN to build the saturating perf counters;
// otherwise both counters read 0 and no counter flops exist.
module idex_skid_reg #(
  parameter int XLEN    = 64,
  parameter int RA_W    = 5,
  parameter int FUNCT_W = 4,
  parameter int ALUOP_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  idex_skid_reg_if.slave      bus,
  output logic [31:0]         stall_cnt,
  output logic [15:0]         flush_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    rdata1;
    logic [XLEN-1:0]    rdata2;
    logic [XLEN-1:0]    imm;
    logic [RA_W-1:0]    rs1;
    logic [RA_W-1:0]    rs2;
    logic [RA_W-1:0]    rd;
    logic [FUNCT_W-1:0] funct;
    logic [5:0]         ctrl;
    logic [ALUOP_W-1:0] aluop;
  } bundle_t;

  bundle_t in_b;
  bundle_t main_q;
  bundle_t skid_q;
  logic    main_valid;
  logic    skid_valid;
  logic    accept;
  logic    consume;

  assign in_b.pc     = bus.pc_in;
  assign in_b.rdata1 = bus.rdata1_in;
  assign in_b.rdata2 = bus.rdata2_in;
  assign in_b.imm    = bus.imm_in;
  assign in_b.rs1    = bus.rs1_in;
  assign in_b.rs2    = bus.rs2_in;
  assign in_b.rd     = bus.rd_in;
  assign in_b.funct  = bus.funct_in;
  assign in_b.ctrl   = bus.ctrl_in;
  assign in_b.aluop  = bus.aluop_in;

  assign accept  = bus.in_valid && !skid_valid;
  assign consume = main_valid && bus.out_ready;

  // ctrl/aluop in main_q are cleared whenever main goes empty, so the
  // outputs stay purely registered and bubbles never carry live control.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      // data fields hold; only validity and control are squashed
      main_valid   <= 1'b0;
      skid_valid   <= 1'b0;
      main_q.ctrl  <= '0;
      main_q.aluop <= '0;
    end else if (!main_valid || consume) begin
      if (skid_valid) begin
        // oldest bundle sits in skid; incoming is refused since in_ready=0
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (bus.in_valid) begin
        main_q     <= in_b;
        main_valid <= 1'b1;
      end else begin
        main_valid   <= 1'b0;
        main_q.ctrl  <= '0;
        main_q.aluop <= '0;
      end
    end else if (accept) begin
      // main held by execute: park the new bundle in skid
      skid_q     <= in_b;
      skid_valid <= 1'b1;
    end
  end

  assign bus.in_ready  = !skid_valid;
  assign bus.out_valid = main_valid;
  assign bus.pc        = main_q.pc;
  assign bus.rdata1    = main_q.rdata1;
  assign bus.rdata2    = main_q.rdata2;
  assign bus.imm       = main_q.imm;
  assign bus.rs1       = main_q.rs1;
  assign bus.rs2       = main_q.rs2;
  assign bus.rd        = main_q.rd;
  assign bus.funct_out = main_q.funct;
  assign bus.ctrl_out  = main_q.ctrl;
  assign bus.aluop     = main_q.aluop;

`ifdef IDEX_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [15:0] flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (main_valid && !bus.out_ready && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (flush && (flush_q != 16'hFFFF)) begin
        flush_q <= flush_q + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_idex_skid_reg.sv
// tb_idex_skid_reg: scoreboard bench for idex_skid_reg (directed scenarios plus a random stream).
module tb_idex_skid_reg;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  idex_skid_reg_if #(.XLEN(64), .RA_W(5), .FUNCT_W(4), .ALUOP_W(2)) bus ();

  idex_skid_reg #(.XLEN(64), .RA_W(5), .FUNCT_W(4), .ALUOP_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] rdata1;
    logic [63:0] rdata2;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic [3:0]  funct;
    logic [5:0]  ctrl;
    logic [1:0]  aluop;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] exp_stall = 0;
  logic [15:0] exp_flush = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // bundle fields are derived from pc so each bundle is distinguishable
  task automatic drive(input logic v, input logic [63:0] p);
    bus.in_valid  = v;
    bus.pc_in     = p;
    bus.rdata1_in = p ^ 64'hA5A5_5A5A_0F0F_F0F0;
    bus.rdata2_in = ~p;
    bus.imm_in    = p << 2;
    bus.rs1_in    = p[6:2];
    bus.rs2_in    = p[7:3];
    bus.rd_in     = p[8:4];
    bus.funct_in  = p[5:2];
    bus.ctrl_in   = p[9:4];
    bus.aluop_in  = p[3:2];
  endtask

  // Scoreboard monitor: decides what the upcoming edge will do from the
  // handshake signals, well away from the edge itself.
  always @(negedge clk) begin
    exp_t e;
    exp_t got;
    if (reset) begin
      sb_q.delete();
      exp_stall = 0;
      exp_flush = 0;
    end else begin
`ifdef IDEX_PERF_CNT_EN
      check_val("stall_cnt_model", 64'(stall_cnt), 64'(exp_stall));
      check_val("flush_cnt_model", 64'(flush_cnt), 64'(exp_flush));
`else
      check_val("stall_cnt_zero", 64'(stall_cnt), 64'd0);
      check_val("flush_cnt_zero", 64'(flush_cnt), 64'd0);
`endif
      if (!bus.out_valid)
        check_val("bubble_ctrl", {56'd0, bus.ctrl_out, bus.aluop}, 64'd0);
      if (bus.out_valid && !bus.out_ready) exp_stall = exp_stall + 1;
      if (flush) begin
        exp_flush = exp_flush + 1;
        sb_q.delete();
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          if (sb_q.size() == 0) begin
            check_val("unexpected_out", bus.pc, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = sb_q.pop_front();
            got.pc = bus.pc; got.rdata1 = bus.rdata1; got.rdata2 = bus.rdata2;
            got.imm = bus.imm; got.rd = bus.rd; got.funct = bus.funct_out;
            got.ctrl = bus.ctrl_out; got.aluop = bus.aluop;
            check_val("sb_pc", got.pc, e.pc);
            check_val("sb_rdata1", got.rdata1, e.rdata1);
            check_val("sb_rdata2", got.rdata2, e.rdata2);
            check_val("sb_imm", got.imm, e.imm);
            check_val("sb_misc", {47'd0, got.rd, got.funct, got.ctrl},
                      {47'd0, e.rd, e.funct, e.ctrl});
            check_val("sb_aluop", 64'(got.aluop), 64'(e.aluop));
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          e.pc = bus.pc_in; e.rdata1 = bus.rdata1_in; e.rdata2 = bus.rdata2_in;
          e.imm = bus.imm_in; e.rd = bus.rd_in; e.funct = bus.funct_in;
          e.ctrl = bus.ctrl_in; e.aluop = bus.aluop_in;
          sb_q.push_back(e);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b1, 64'hDEAD_0000);

    // reset with in_valid held high
    cyc();
    cyc();
    check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_val("rst_pc", bus.pc, 64'd0);
    check_val("rst_data", bus.rdata1 | bus.rdata2 | bus.imm, 64'd0);
    check_val("rst_ids", {49'd0, bus.rs1, bus.rs2, bus.rd}, 64'd0);
    check_val("rst_ctrl", {52'd0, bus.funct_out, bus.ctrl_out, bus.aluop}, 64'd0);
    check_val("rst_cnts", {16'd0, flush_cnt, stall_cnt}, 64'd0);

    // streaming at full throughput
    reset = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h1000 + 64'(4 * i));
      cyc();
      check_val("stream_pc", bus.pc, 64'h1000 + 64'(4 * i));
      check_val("stream_valid", 64'(bus.out_valid), 64'd1);
      check_val("stream_in_ready", 64'(bus.in_ready), 64'd1);
    end
    drive(1'b0, 64'h0);
    cyc();
    check_val("stream_drained", 64'(bus.out_valid), 64'd0);

    // stall fills skid, then drains in order
    bus.out_ready = 1'b0;
    drive(1'b1, 64'h2000);
    cyc();
    check_val("stall_pc0", bus.pc, 64'h2000);
    check_val("stall_rdy0", 64'(bus.in_ready), 64'd1);
    drive(1'b1, 64'h2004);
    cyc();
    check_val("stall_pc1", bus.pc, 64'h2000);
    check_val("stall_rdy1", 64'(bus.in_ready), 64'd0);
    drive(1'b0, 64'h0);
    bus.out_ready = 1'b1;
    cyc();
    check_val("drain_pc", bus.pc, 64'h2004);
    check_val("drain_rdy", 64'(bus.in_ready), 64'd1);
    cyc();
    check_val("drain_empty", 64'(bus.out_valid), 64'd0);

    // flush with both entries full and a bundle presented
    bus.out_ready = 1'b0;
    drive(1'b1, 64'h2100);
    bus.ctrl_in = 6'b000010;
    cyc();
    drive(1'b1, 64'h2104);
    bus.ctrl_in = 6'b000010;
    cyc();
    check_val("pre_flush_rdy", 64'(bus.in_ready), 64'd0);
    flush = 1'b1;
    drive(1'b1, 64'h3000);
    cyc();
    flush = 1'b0;
    drive(1'b0, 64'h0);
    check_val("flush_valid", 64'(bus.out_valid), 64'd0);
    check_val("flush_ctrl", 64'(bus.ctrl_out), 64'd0);
    check_val("flush_aluop", 64'(bus.aluop), 64'd0);
    check_val("flush_rdy", 64'(bus.in_ready), 64'd1);
    check_val("flush_pc_hold", bus.pc, 64'h2100);
    bus.out_ready = 1'b1;
    cyc();
    cyc();
    check_val("post_flush_valid", 64'(bus.out_valid), 64'd0);

    // reset and flush together over a full stage
    bus.out_ready = 1'b0;
    drive(1'b1, 64'h4000);
    cyc();
    reset = 1'b1;
    flush = 1'b1;
    cyc();
    check_val("rf_valid", 64'(bus.out_valid), 64'd0);
    check_val("rf_pc", bus.pc, 64'd0);
    check_val("rf_rdy", 64'(bus.in_ready), 64'd1);
    check_val("rf_flush_cnt", 64'(flush_cnt), 64'd0);
    check_val("rf_stall_cnt", 64'(stall_cnt), 64'd0);
    reset = 1'b0;
    flush = 1'b0;

    // perf counters: 10 stalled cycles, then 3 flush pulses
    drive(1'b1, 64'h5000);
    cyc();
    drive(1'b0, 64'h0);
    repeat (10) cyc();
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    flush = 1'b1;
    repeat (3) cyc();
    flush = 1'b0;
`ifdef IDEX_PERF_CNT_EN
    check_val("perf_stall", 64'(stall_cnt), 64'd10);
    check_val("perf_flush", 64'(flush_cnt), 64'd3);
`else
    check_val("perf_stall", 64'(stall_cnt), 64'd0);
    check_val("perf_flush", 64'(flush_cnt), 64'd0);
`endif

    // random stream with occasional flushes
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 64'h8000 + 64'(4 * i));
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 15) == 0);
      cyc();
    end
    flush = 1'b0;
    drive(1'b0, 64'h0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) cyc();
    cyc();
    check_val("final_sb_empty", 64'(sb_q.size()), 64'd0);
    check_val("final_out_valid", 64'(bus.out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
